// File: rtl/vga_text_fetcher.sv
// vga_text_fetcher: refreshes the whole char-buffer RAM from packed text words in system memory.
// Latency: first mem_req the cycle after start; each word = 1 REQ cycle (+ ack wait) + CPW write cycles.
// Backpressure: mem_req/mem_add held until mem_ack; starts while busy collapse into one queued frame.
module vga_text_fetcher #(
   parameter int                WORD_SIZE      = 32,
   parameter int                ASCII_SIZE     = 8,
   parameter int                CHARS_HORZ     = 80,
   parameter int                CHARS_VERT     = 30,
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] VGA_MEM_OFFSET = '0,
   parameter bit                BIT_REVERSE    = 1'b1,
   localparam int               ROW_W          = (CHARS_VERT > 1) ? $clog2(CHARS_VERT) : 1,
   localparam int               COL_W          = (CHARS_HORZ > 1) ? $clog2(CHARS_HORZ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_add,
   input  logic                  mem_ack,
   input  logic [WORD_SIZE-1:0]  mem_data,
   output logic                  buf_we,
   output logic [ROW_W-1:0]      buf_row,
   output logic [COL_W-1:0]      buf_col,
   output logic [ASCII_SIZE-1:0] buf_char,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CPW    = WORD_SIZE / ASCII_SIZE;
   localparam int NWORDS = (CHARS_HORZ * CHARS_VERT) / CPW;
   localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int LANE_W = (CPW > 1) ? $clog2(CPW) : 1;

   // Geometry must split cleanly into whole characters and whole words per row.
   if ((WORD_SIZE % ASCII_SIZE) != 0) begin : g_bad_word_size
      $error("vga_text_fetcher: WORD_SIZE must be a multiple of ASCII_SIZE");
   end
   if ((CHARS_HORZ % (WORD_SIZE / ASCII_SIZE)) != 0) begin : g_bad_row_size
      $error("vga_text_fetcher: CHARS_HORZ must be a multiple of WORD_SIZE/ASCII_SIZE");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      UNPACK = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                           state;
   state_t                           state_next;
   logic [WIDX_W-1:0]                word_idx;
   logic [ROW_W-1:0]                 row;
   logic [COL_W-1:0]                 col;
   logic [LANE_W-1:0]                lane;
   logic                             pending;
   logic [CPW-1:0][ASCII_SIZE-1:0]   word_q;
   logic [ASCII_SIZE-1:0]            lane_bits;
   logic [ASCII_SIZE-1:0]            char_rev;
   logic                             last_lane;
   logic                             last_word;
   logic                             last_col;

   assign last_lane = (lane == LANE_W'(CPW - 1));
   assign last_word = (word_idx == WIDX_W'(NWORDS - 1));
   assign last_col  = (col == COL_W'(CHARS_HORZ - 1));

   // Select the current lane of the latched word and build its bit-mirrored form.
   always_comb begin
      lane_bits = word_q[lane];
      char_rev  = '0;
      for (int b = 0; b < ASCII_SIZE; b++) begin
         char_rev[b] = lane_bits[ASCII_SIZE-1-b];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and outputs; every output is forced to 0 outside the state that owns it.
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_add    = '0;
      buf_we     = 1'b0;
      buf_row    = '0;
      buf_col    = '0;
      buf_char   = '0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = REQ;
            end
         end
         REQ: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            mem_add = VGA_MEM_OFFSET + ADDR_W'(word_idx);
            if (mem_ack) begin
               state_next = UNPACK;
            end
         end
         UNPACK: begin
            busy     = 1'b1;
            buf_we   = 1'b1;
            buf_row  = row;
            buf_col  = col;
            buf_char = BIT_REVERSE ? char_rev : lane_bits;
            if (last_lane) begin
               state_next = last_word ? DONE : REQ;
            end
         end
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
            // A start landing in this very cycle counts as a queued frame.
            state_next = (pending || start) ? REQ : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Queued-frame flag: any start seen while busy, consumed when the frame finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (state == DONE) begin
         pending <= 1'b0;
      end else if ((state != IDLE) && start) begin
         pending <= 1'b1;
      end
   end

   // Word latch plus word/lane/row/column position counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx <= '0;
         row      <= '0;
         col      <= '0;
         lane     <= '0;
         word_q   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // Every frame begins at screen position 0.
               word_idx <= '0;
               row      <= '0;
               col      <= '0;
               lane     <= '0;
            end
            REQ: begin
               // Data is only trusted on the ack cycle of an outstanding request.
               if (mem_ack) begin
                  word_q <= mem_data;
                  lane   <= '0;
               end
            end
            UNPACK: begin
               if (last_col) begin
                  col <= '0;
                  row <= row + ROW_W'(1);
               end else begin
                  col <= col + COL_W'(1);
               end
               if (last_lane) begin
                  lane     <= '0;
                  word_idx <= word_idx + WIDX_W'(1);
               end else begin
                  lane <= lane + LANE_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
